// File: rtl/tap_pkg.sv
// Shared TAP definitions: the 16 IEEE 1149.1 controller states with the
// observation-pad codes, the reset state and the TMS=1 flush length.
package tap_pkg;

    // 4-bit state code is exactly what appears on the observation pads;
    // all 16 codes are used, so there are no illegal states.
    typedef enum logic [3:0] {
        TAP_EX2DR = 4'h0,
        TAP_EX1DR = 4'h1,
        TAP_SHDR  = 4'h2,
        TAP_PAUDR = 4'h3,
        TAP_SELIR = 4'h4,
        TAP_UPDDR = 4'h5,
        TAP_CAPDR = 4'h6,
        TAP_SELDR = 4'h7,
        TAP_EX2IR = 4'h8,
        TAP_EX1IR = 4'h9,
        TAP_SHIR  = 4'hA,
        TAP_PAUIR = 4'hB,
        TAP_RTI   = 4'hC,
        TAP_UPDIR = 4'hD,
        TAP_CAPIR = 4'hE,
        TAP_TLR   = 4'hF
    } tap_state_e;

    localparam tap_state_e TAP_RESET_STATE = TAP_TLR;

    // Consecutive TMS=1 edges guaranteed to land in Test-Logic-Reset.
    localparam int TAP_TLR_TMS_ONES = 5;

endpackage

// File: rtl/tap_fsm_next.sv
// Combinational IEEE 1149.1 next-state function: (state, tms) -> next state.
module tap_fsm_next
    import tap_pkg::*;
(
    input  tap_state_e state,
    input  logic       tms,
    output tap_state_e next
);

    // Standard TAP transition table; DR and IR branches are mirror images.
    always_comb begin
        next = TAP_TLR;
        case (state)
            TAP_TLR:   next = tms ? TAP_TLR   : TAP_RTI;
            TAP_RTI:   next = tms ? TAP_SELDR : TAP_RTI;
            TAP_SELDR: next = tms ? TAP_SELIR : TAP_CAPDR;
            TAP_SELIR: next = tms ? TAP_TLR   : TAP_CAPIR;

            TAP_CAPDR: next = tms ? TAP_EX1DR : TAP_SHDR;
            TAP_SHDR:  next = tms ? TAP_EX1DR : TAP_SHDR;
            TAP_EX1DR: next = tms ? TAP_UPDDR : TAP_PAUDR;
            TAP_PAUDR: next = tms ? TAP_EX2DR : TAP_PAUDR;
            TAP_EX2DR: next = tms ? TAP_UPDDR : TAP_SHDR;
            TAP_UPDDR: next = tms ? TAP_SELDR : TAP_RTI;

            TAP_CAPIR: next = tms ? TAP_EX1IR : TAP_SHIR;
            TAP_SHIR:  next = tms ? TAP_EX1IR : TAP_SHIR;
            TAP_EX1IR: next = tms ? TAP_UPDIR : TAP_PAUIR;
            TAP_PAUIR: next = tms ? TAP_EX2IR : TAP_PAUIR;
            TAP_EX2IR: next = tms ? TAP_UPDIR : TAP_SHIR;
            TAP_UPDIR: next = tms ? TAP_SELDR : TAP_RTI;
        endcase
    end

endmodule

// File: rtl/tap_route.sv
// TAP controller with its encoded state driven onto four observation pads.
// Optional build macro TAP_ROUTE_OBS_PIPE_EN adds one register stage between
// the state register and the pads (2-edge TMS-to-pad latency).
module tap_route
    import tap_pkg::*;
(
    input  logic GCLK_Pad,
    input  logic TRST_Pad,
    input  logic TMS_Pad,
    output logic state_obs0_Pad,
    output logic state_obs1_Pad,
    output logic state_obs2_Pad,
    output logic state_obs3_Pad
);

    tap_state_e state_q;
    tap_state_e state_d;
    logic [3:0] obs_code;

    tap_fsm_next u_next (
        .state (state_q),
        .tms   (TMS_Pad),
        .next  (state_d)
    );

    // State register; reset wins over any transition, including mid-shift.
    always_ff @(posedge GCLK_Pad) begin
        if (TRST_Pad)
            state_q <= TAP_RESET_STATE;
        else
            state_q <= state_d;
    end

`ifdef TAP_ROUTE_OBS_PIPE_EN
    logic [3:0] obs_q;

    // Pad pipe stage; resets alongside the state so pads read TLR on the reset edge.
    always_ff @(posedge GCLK_Pad) begin
        if (TRST_Pad)
            obs_q <= TAP_RESET_STATE;
        else
            obs_q <= state_q;
    end

    assign obs_code = obs_q;
`else
    assign obs_code = state_q;
`endif

    assign state_obs0_Pad = obs_code[0];
    assign state_obs1_Pad = obs_code[1];
    assign state_obs2_Pad = obs_code[2];
    assign state_obs3_Pad = obs_code[3];

endmodule

// File: tb/tb_tap_route.sv
// Directed bench for tap_route: walks the DR and IR branches, the TMS=1 flush
// to TLR and reset priority, against hand-computed pad codes.
module tb_tap_route;
    import tap_pkg::*;

`ifdef TAP_ROUTE_OBS_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    logic clk = 1'b0;
    logic trst = 1'b0;
    logic tms = 1'b0;
    logic o0, o1, o2, o3;
    logic [3:0] obs;
    logic [3:0] exp_d = 4'hF;
    int nvec = 0;
    int nerr = 0;

    assign obs = {o3, o2, o1, o0};

    always #5 clk = ~clk;

    tap_route dut (
        .GCLK_Pad       (clk),
        .TRST_Pad       (trst),
        .TMS_Pad        (tms),
        .state_obs0_Pad (o0),
        .state_obs1_Pad (o1),
        .state_obs2_Pad (o2),
        .state_obs3_Pad (o3)
    );

    // Drive inputs away from the edge, clock once, sample 1 time unit later.
    // exp is the state-register value after the edge; with the pipe the pads
    // show the previous one, except on a reset edge where both read TLR.
    task automatic step(input logic r, input logic m, input logic [3:0] exp,
                        input string tag);
        logic [3:0] want;
        @(negedge clk);
        trst = r;
        tms  = m;
        @(posedge clk);
        #1;
        want = (PIPE && !r) ? exp_d : exp;
        nvec++;
        assert (obs === want)
        else begin
            nerr++;
            $error("FAIL %s: obs=%h expected=%h", tag, obs, want);
        end
        exp_d = exp;
    endtask

    initial begin
        // Reset
        step(1, 0, 4'hF, "reset0");
        step(1, 1, 4'hF, "reset1");

        // Idle in RTI
        step(0, 0, 4'hC, "rti0");
        step(0, 0, 4'hC, "rti1");
        step(0, 0, 4'hC, "rti2");

        // DR branch
        step(0, 1, 4'h7, "seldr");
        step(0, 0, 4'h6, "capdr");
        step(0, 0, 4'h2, "shdr0");
        step(0, 0, 4'h2, "shdr1");
        step(0, 1, 4'h1, "ex1dr");
        step(0, 1, 4'h5, "upddr");
        step(0, 0, 4'hC, "rti_dr");

        // IR branch
        step(0, 1, 4'h7, "seldr_i");
        step(0, 1, 4'h4, "selir");
        step(0, 0, 4'hE, "capir");
        step(0, 0, 4'hA, "shir0");
        step(0, 1, 4'h9, "ex1ir0");
        step(0, 0, 4'hB, "pauir");
        step(0, 1, 4'h8, "ex2ir");
        step(0, 0, 4'hA, "shir1");
        step(0, 1, 4'h9, "ex1ir1");
        step(0, 1, 4'hD, "updir");
        step(0, 1, 4'h7, "seldr_u");

        // Into ShDR, then TMS=1 flush to TLR
        step(0, 0, 4'h6, "capdr_f");
        step(0, 0, 4'h2, "shdr_f");
        step(0, 1, 4'h1, "flush1");
        step(0, 1, 4'h5, "flush2");
        step(0, 1, 4'h7, "flush3");
        step(0, 1, 4'h4, "flush4");
        step(0, 1, 4'hF, "flush5");
        for (int i = 0; i < TAP_TLR_TMS_ONES; i++)
            step(0, 1, 4'hF, "tlr_hold");

        // Reset with TMS=1 while shifting DR
        step(0, 0, 4'hC, "rti_r1");
        step(0, 1, 4'h7, "seldr_r1");
        step(0, 0, 4'h6, "capdr_r1");
        step(0, 0, 4'h2, "shdr_r1");
        step(1, 1, 4'hF, "trst_shdr");

        // Reset with TMS=0 from PauIR
        step(0, 0, 4'hC, "rti_r2");
        step(0, 1, 4'h7, "seldr_r2");
        step(0, 1, 4'h4, "selir_r2");
        step(0, 0, 4'hE, "capir_r2");
        step(0, 1, 4'h9, "ex1ir_r2");
        step(0, 0, 4'hB, "pauir_r2");
        step(1, 0, 4'hF, "trst_pauir");
        step(0, 0, 4'hC, "rti_post");
        step(0, 0, 4'hC, "rti_post2");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
